alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The module SHALL have parameter N, default 32, setting the datapath width.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 StallE  input  1  hold the E register contents.
REQ-005 FlushE  input  1  load a bubble into the E register.
REQ-006 ValidD  input  1  a decoded instruction is present in D.
REQ-007 OpD  input  7  RISC-V opcode.
REQ-008 Funct3D  input  3  RISC-V funct3.
REQ-009 Funct7b5D  input  1  instruction bit 30.
REQ-010 RD1D, RD2D  input  N  register-file read data.
REQ-011 ImmExtD  input  N  sign-extended immediate.
REQ-012 ForwardAE, ForwardBE  input  2  operand-forward selects.
REQ-013 ALUResultM  input  N  M-stage ALU result.
REQ-014 ResultW  input  N  W-stage writeback value.
REQ-015 SrcAE, SrcBE  output  N  ALU operands.
REQ-016 ALUControlE  output  3  ALU operation select.
REQ-017 WriteDataE  output  N  store data (forwarded RD2).
REQ-018 ValidE  output  1  E holds a valid, legal instruction.
REQ-019 IllegalE  output  1  E holds an instruction with an undecodable ALU operation.
REQ-020 IssueCount  output  16  count of legal instructions issued.

Function
REQ-021 The decode table SHALL be as follows; every unlisted combination is illegal, with ALUControl = 000:
- R-type (0110011): f3 000/f7b5 0 -> 000 add; f3 000/f7b5 1 -> 001 sub; f3 111 -> 010 and; f3 110 -> 011 or.
- I-type ALU (0010011): f3 000 -> 000; f3 111 -> 010; f3 110 -> 011; Funct7b5 is ignored.
- Load (0000011) and store (0100011): 000 with the immediate.
- Branch (1100011), any f3: 001 with RD2.
REQ-022 ALUSrc SHALL be 1 (immediate) for the I-type, load and store opcodes, and 0 otherwise.
REQ-023 The E register SHALL hold RD1, RD2, ImmExt, ALUControl, ALUSrc, Valid and Illegal, with one-cycle latency from D to E.
REQ-024 Register-update priority SHALL be: FlushE first (bubble: all fields 0), then StallE (hold), otherwise load from D.
REQ-025 When ValidD=0, a load SHALL produce a bubble.
REQ-026 ValidE SHALL equal the registered ValidD AND NOT illegal.
REQ-027 IllegalE SHALL equal the registered ValidD AND illegal.
REQ-028 Forwarding SHALL be combinational after the register: select 00 -> RD1E/RD2E, 01 -> ResultW, 10 -> ALUResultM, 11 -> RD1E/RD2E.
REQ-029 SrcAE SHALL be the forwarded A operand.
REQ-030 WriteDataE SHALL be the forwarded B operand.
REQ-031 SrcBE SHALL be ImmExtE when ALUSrcE=1, and the forwarded B operand otherwise.
REQ-032 IssueCount SHALL increment by 1 on each edge that loads a legal valid instruction (no flush, no stall), and SHALL saturate at 16'hFFFF.
REQ-033 A stalled or flushed cycle SHALL NOT increment IssueCount.

Reset
REQ-034 While rst_n=0, all E fields and IssueCount SHALL be 0 asynchronously.
REQ-035 Reset outputs SHALL be: ValidE=0, IllegalE=0, ALUControlE=000, SrcAE/SrcBE/WriteDataE equal to the forwarding result over zeroed registers.
REQ-036 Reset deassertion SHALL take effect on the first following rising edge.
REQ-037 Reset mid-stall SHALL discard the held instruction.

Structure
REQ-038 Opcode constants, ALUControl encodings (ADD=000, SUB=001, AND=010, OR=011) and forward-select encodings SHALL reside in a shared package.
REQ-039 The decode table SHALL be a combinational sub-module named alu_decoder.

Verification
REQ-040 add: ValidD=1, R-type, f3=000, f7b5=0, RD1D=5, RD2D=7 -> next cycle ALUControlE=000, SrcAE=5, SrcBE=7, ValidE=1, IssueCount=1.
REQ-041 Load: OpD=0000011, ImmExtD=0xFFFFFFFC, RD2D=9 -> SrcBE=0xFFFFFFFC, WriteDataE=9.
REQ-042 Stall and flush: StallE=1 for 3 cycles while D changes -> E unchanged and IssueCount unchanged; StallE=1 with FlushE=1 -> ValidE=0, ALUControlE=000.
REQ-043 Forwarding: ForwardAE=10 with ALUResultM=0x1234 -> SrcAE=0x1234; ForwardBE=01 with ResultW=0xAB and ALUSrcE=0 -> SrcBE=0xAB and WriteDataE=0xAB.
REQ-044 Illegal op: R-type f3=001 -> IllegalE=1, ValidE=0, IssueCount unchanged.
REQ-045 Saturation and reset: IssueCount preloaded to 0xFFFE, 3 legal issues -> count holds 0xFFFF; asserting rst_n=0 mid-clock-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_pkg
// Shared constants for the ALU issue stage:
//   - RISC-V opcodes recognised by the ALU decoder
//   - ALUControl encodings driven to the execute stage
//   - operand-forward select encodings
// ---------------------------------------------------------------------------
package alu_issue_stage_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_ctrl_e;

    // 00 and 11 both select the register-file value held in E.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10,
        FWD_RF2 = 2'b11
    } fwd_sel_e;

    localparam logic [15:0] ISSUE_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Purely combinational decode of opcode/funct3/funct7b5 into the ALU
// operation, operand-B source and an illegal flag.
// Ports:
//   op           in  7  RISC-V opcode
//   funct3       in  3  funct3 field
//   funct7b5     in  1  instruction bit 30
//   alu_control  out 3  ALU operation (000 for any illegal combination)
//   alu_src      out 1  1 = operand B is the immediate
//   illegal      out 1  combination is not in the decode table
// ---------------------------------------------------------------------------
module alu_decoder
    import alu_issue_stage_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       alu_src,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        alu_src     = 1'b0;
        illegal     = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
                        illegal     = 1'b0;
                    end
                    3'b111: begin
                        alu_control = ALU_AND;
                        illegal     = 1'b0;
                    end
                    3'b110: begin
                        alu_control = ALU_OR;
                        illegal     = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_ITYPE: begin
                // funct7b5 is ignored: there is no immediate subtract.
                alu_src = 1'b1;
                case (funct3)
                    3'b000: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b0;
                    end
                    3'b111: begin
                        alu_control = ALU_AND;
                        illegal     = 1'b0;
                    end
                    3'b110: begin
                        alu_control = ALU_OR;
                        illegal     = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                // Address generation: base + immediate.
                alu_control = ALU_ADD;
                alu_src     = 1'b1;
                illegal     = 1'b0;
            end
            OP_BRANCH: begin
                // Compare by subtraction against RD2, for every funct3.
                alu_control = ALU_SUB;
                illegal     = 1'b0;
            end
            default: ;
        endcase
        // An illegal combination always reports ADD so E never carries junk.
        if (illegal) begin
            alu_control = ALU_ADD;
            alu_src     = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// D->E pipeline register for the ALU path with decode, operand forwarding
// and a saturating count of issued legal instructions.
//
// Flow control: ValidD marks an instruction present in D; there is no
// ready back-pressure. On each rising edge E is bubbled by FlushE (highest
// priority), held by StallE, or loaded from D (a bubble when ValidD=0).
// An instruction is "issued" only on an edge that loads a valid, legal D.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   StallE, FlushE             E-register hold / bubble controls
//   ValidD, OpD, Funct3D,
//   Funct7b5D                  decoded-instruction presence and fields
//   RD1D, RD2D, ImmExtD        operand data from D            (N bits)
//   ForwardAE, ForwardBE       operand-forward selects        (2 bits)
//   ALUResultM, ResultW        forwarded values from M and W  (N bits)
//   SrcAE, SrcBE, WriteDataE   ALU operands and store data    (N bits)
//   ALUControlE                ALU operation                  (3 bits)
//   ValidE, IllegalE           E holds a legal / illegal instruction
//   IssueCount                 saturating legal-issue count   (16 bits)
// ---------------------------------------------------------------------------
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         StallE,
    input  logic         FlushE,
    input  logic         ValidD,
    input  logic [6:0]   OpD,
    input  logic [2:0]   Funct3D,
    input  logic         Funct7b5D,
    input  logic [N-1:0] RD1D,
    input  logic [N-1:0] RD2D,
    input  logic [N-1:0] ImmExtD,
    input  logic [1:0]   ForwardAE,
    input  logic [1:0]   ForwardBE,
    input  logic [N-1:0] ALUResultM,
    input  logic [N-1:0] ResultW,
    output logic [N-1:0] SrcAE,
    output logic [N-1:0] SrcBE,
    output logic [2:0]   ALUControlE,
    output logic [N-1:0] WriteDataE,
    output logic         ValidE,
    output logic         IllegalE,
    output logic [15:0]  IssueCount
);

    logic [2:0] dec_alu_control;
    logic       dec_alu_src;
    logic       dec_illegal;

    alu_decoder u_alu_decoder (
        .op          (OpD),
        .funct3      (Funct3D),
        .funct7b5    (Funct7b5D),
        .alu_control (dec_alu_control),
        .alu_src     (dec_alu_src),
        .illegal     (dec_illegal)
    );

    logic [N-1:0] rd1_q,     rd1_d;
    logic [N-1:0] rd2_q,     rd2_d;
    logic [N-1:0] imm_q,     imm_d;
    logic [2:0]   alu_ctl_q, alu_ctl_d;
    logic         alu_src_q, alu_src_d;
    logic         valid_q,   valid_d;
    logic         illegal_q, illegal_d;
    logic [15:0]  issue_cnt_q, issue_cnt_d;

    logic load_en;
    assign load_en = !FlushE && !StallE;

    always_comb begin
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        imm_d       = imm_q;
        alu_ctl_d   = alu_ctl_q;
        alu_src_d   = alu_src_q;
        valid_d     = valid_q;
        illegal_d   = illegal_q;
        issue_cnt_d = issue_cnt_q;

        if (FlushE || (load_en && !ValidD)) begin
            rd1_d     = '0;
            rd2_d     = '0;
            imm_d     = '0;
            alu_ctl_d = ALU_ADD;
            alu_src_d = 1'b0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (load_en) begin
            rd1_d     = RD1D;
            rd2_d     = RD2D;
            imm_d     = ImmExtD;
            alu_ctl_d = dec_alu_control;
            alu_src_d = dec_alu_src;
            valid_d   = 1'b1;
            illegal_d = dec_illegal;
        end

        if (load_en && ValidD && !dec_illegal && (issue_cnt_q != ISSUE_COUNT_MAX)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            alu_ctl_q   <= ALU_ADD;
            alu_src_q   <= 1'b0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            alu_ctl_q   <= alu_ctl_d;
            alu_src_q   <= alu_src_d;
            valid_q     <= valid_d;
            illegal_q   <= illegal_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Forwarding sits after the register so late M/W results reach the ALU.
    logic [N-1:0] fwd_a;
    logic [N-1:0] fwd_b;

    always_comb begin
        fwd_a = rd1_q;
        case (ForwardAE)
            FWD_W:   fwd_a = ResultW;
            FWD_M:   fwd_a = ALUResultM;
            default: fwd_a = rd1_q;
        endcase
        fwd_b = rd2_q;
        case (ForwardBE)
            FWD_W:   fwd_b = ResultW;
            FWD_M:   fwd_b = ALUResultM;
            default: fwd_b = rd2_q;
        endcase
    end

    assign SrcAE       = fwd_a;
    assign WriteDataE  = fwd_b;
    assign SrcBE       = alu_src_q ? imm_q : fwd_b;
    assign ALUControlE = alu_ctl_q;
    assign ValidE      = valid_q && !illegal_q;
    assign IllegalE    = valid_q && illegal_q;
    assign IssueCount  = issue_cnt_q;

endmodule
